// File: rtl/md_unit.sv
// Multiply/divide unit with architectural HI/LO registers for the Execute stage.
// Multi-cycle ops latch their operands, count down a fixed latency, then commit HI/LO.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [2:0]         op_q, op_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic               busy_q, busy_d;

  logic [63:0] prod_u;
  logic [63:0] prod_s;
  logic [31:0] safe_b;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] quot_u;
  logic [31:0] rem_u;
  logic [31:0] quot_mag;
  logic [31:0] rem_mag;
  logic [31:0] quot_s;
  logic [31:0] rem_s;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        div_by_zero;
  logic        is_div_op;

  // Results come from the latched operands only, so the forwarded sources may change mid-run.
  always_comb begin
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};

    div_by_zero = (b_q == 32'd0);
    safe_b      = div_by_zero ? 32'd1 : b_q;
    quot_u      = a_q / safe_b;
    rem_u       = a_q % safe_b;

    // Signed divide via magnitudes avoids the 0x80000000 / -1 overflow corner.
    abs_a    = a_q[31] ? (~a_q + 32'd1) : a_q;
    abs_b    = safe_b[31] ? (~safe_b + 32'd1) : safe_b;
    quot_mag = abs_a / abs_b;
    rem_mag  = abs_a % abs_b;
    quot_s   = (a_q[31] ^ safe_b[31]) ? (~quot_mag + 32'd1) : quot_mag;
    rem_s    = a_q[31] ? (~rem_mag + 32'd1) : rem_mag;

    is_div_op = (op_q == OP_DIV) || (op_q == OP_DIVU);

    res_hi = hi_q;
    res_lo = lo_q;
    case (op_q)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      OP_DIV: begin
        res_hi = rem_s;
        res_lo = quot_s;
      end
      OP_DIVU: begin
        res_hi = rem_u;
        res_lo = quot_u;
      end
      default: begin
        res_hi = hi_q;
        res_lo = lo_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          case (md_op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              state_d = RUN;
              busy_d  = 1'b1;
              op_d    = md_op;
              a_d     = src_a;
              b_d     = src_b;
              count_d = ((md_op == OP_MULT) || (md_op == OP_MULTU)) ?
                        CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            end
            OP_MTHI: hi_d = src_a;
            OP_MTLO: lo_d = src_a;
            default: ;
          endcase
        end
      end
      RUN: begin
        // Any start seen here is ignored; the in-flight op finishes untouched.
        if (count_q == CNT_W'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          count_d = '0;
          if (!(is_div_op && div_by_zero)) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      op_q    <= 3'b000;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus queues expected HI/LO and busy length,
// a negedge monitor checks hold values during busy and the result when busy drops.
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] hold_hi;
    logic [31:0] hold_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cycles;
    int          id;
  } exp_t;

  exp_t exp_q[$];

  logic [31:0] model_hi;
  logic [31:0] model_lo;
  int          next_id;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  // Push the expected outcome, then issue one start cycle; returns one cycle after the start edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] eh, input logic [31:0] el, input int cyc);
    exp_t e;
    e.hold_hi = model_hi;
    e.hold_lo = model_lo;
    e.exp_hi  = eh;
    e.exp_lo  = el;
    e.cycles  = cyc;
    e.id      = next_id;
    next_id++;
    exp_q.push_back(e);
    model_hi = eh;
    model_lo = el;
    @(posedge clk);
    #1;
    start = 1'b1;
    md_op = op;
    src_a = a;
    src_b = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    md_op = 3'b000;
  endtask

  task automatic waitIdle(input int max_cycles);
    logic done;
    done = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput("wait_idle", {31'd0, done}, 32'd1);
  endtask

  // Monitor: checks hold values while busy and pops the scoreboard when busy falls.
  logic prev_busy = 1'b0;
  int   busy_cnt  = 0;
  always @(negedge clk) begin
    if (busy === 1'b1) begin
      busy_cnt++;
      if (exp_q.size() == 0) begin
        checkOutput("busy_without_op", 32'd1, 32'd0);
      end else begin
        checkOutput($sformatf("hold_hi_op%0d", exp_q[0].id), hi, exp_q[0].hold_hi);
        checkOutput($sformatf("hold_lo_op%0d", exp_q[0].id), lo, exp_q[0].hold_lo);
      end
    end else if (prev_busy === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("result_without_op", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput($sformatf("busy_len_op%0d", e.id), busy_cnt, e.cycles);
        checkOutput($sformatf("hi_op%0d", e.id), hi, e.exp_hi);
        checkOutput($sformatf("lo_op%0d", e.id), lo, e.exp_lo);
      end
      busy_cnt = 0;
    end
    prev_busy = busy;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    md_op    = 3'b000;
    src_a    = 32'd0;
    src_b    = 32'd0;
    model_hi = 32'd0;
    model_lo = 32'd0;
    next_id  = 0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);
    reset = 1'b0;

    // multu 0xFFFFFFFF * 2
    applyStimulus(3'b010, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5);
    waitIdle(20);

    // mult -3 * 7 with src_a toggling during the run
    applyStimulus(3'b001, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5);
    for (int i = 0; i < 3; i++) begin
      src_a = ~src_a;
      src_b = src_b + 32'd3;
      @(posedge clk);
      #1;
    end
    waitIdle(20);

    // div -7 / 2, divu 7 / 2, and the most-negative / -1 corner
    applyStimulus(3'b011, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    waitIdle(20);
    applyStimulus(3'b100, 32'd7, 32'd2, 32'd1, 32'd3, 10);
    waitIdle(20);
    applyStimulus(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10);
    waitIdle(20);

    // mthi then mtlo on consecutive cycles
    @(posedge clk);
    #1;
    start = 1'b1;
    md_op = 3'b101;
    src_a = 32'h1234_5678;
    @(posedge clk);
    #1;
    checkOutput("mthi_hi", hi, 32'h1234_5678);
    checkOutput("mthi_lo", lo, 32'h8000_0000);
    checkOutput("mthi_busy", {31'd0, busy}, 32'd0);
    md_op = 3'b110;
    src_a = 32'h9ABC_DEF0;
    @(posedge clk);
    #1;
    start = 1'b0;
    md_op = 3'b000;
    checkOutput("mtlo_hi", hi, 32'h1234_5678);
    checkOutput("mtlo_lo", lo, 32'h9ABC_DEF0);
    checkOutput("mtlo_busy", {31'd0, busy}, 32'd0);
    model_hi = 32'h1234_5678;
    model_lo = 32'h9ABC_DEF0;

    // no-op encodings must not disturb anything
    start = 1'b1;
    md_op = 3'b111;
    src_a = 32'h5555_5555;
    @(posedge clk);
    #1;
    md_op = 3'b000;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("noop_hi", hi, 32'h1234_5678);
    checkOutput("noop_busy", {31'd0, busy}, 32'd0);

    // divu by zero: full latency, HI/LO unchanged
    applyStimulus(3'b100, 32'd99, 32'd0, 32'h1234_5678, 32'h9ABC_DEF0, 10);
    waitIdle(20);

    // divu 100 / 7 with an mthi attempted at busy cycle 3
    applyStimulus(3'b100, 32'd100, 32'd7, 32'd2, 32'd14, 10);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    start = 1'b1;
    md_op = 3'b101;
    src_a = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    start = 1'b0;
    md_op = 3'b000;
    waitIdle(20);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("after_ignored_mthi_hi", hi, 32'd2);

    // mult aborted by reset at busy cycle 2
    applyStimulus(3'b001, 32'd5, 32'd6, 32'd0, 32'd0, 2);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_hi", hi, 32'd0);
    checkOutput("abort_lo", lo, 32'd0);
    repeat (8) @(posedge clk);
    #1;
    checkOutput("abort_late_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_late_hi", hi, 32'd0);
    checkOutput("abort_late_lo", lo, 32'd0);

    @(negedge clk);
    checkOutput("scoreboard_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit with architectural HI/LO registers; sits in the Execute stage alongside the ALU.
- Executes mult/multu/div/divu with fixed multi-cycle latency, signalled by a busy flag. Executes mthi/mtlo in a single cycle.
- hi/lo feed the E→M pipeline register; the Memory stage consumes them as its HI/LO inputs for mfhi/mflo forwarding.
- The hazard unit stalls Decode while an md instruction is in E and (start || busy).

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start (≥1).
- DIV_CYCLES, 10, busy cycles after a div/divu start (≥1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle qualifier: E-stage instruction is an md op, not stalled/flushed
- md_op  in  3  001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo; 000/111 no-op
- src_a  in  32  forwarded rs value
- src_b  in  32  forwarded rt value
- busy  out  1  multi-cycle operation in flight
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Clocking and reset:
  - All state updates on posedge clk.
  - reset has priority over everything: hi=0, lo=0, busy=0, counter=0, pending result discarded.
- States: IDLE, RUN.
- IDLE → RUN: start=1 with md_op in {001..100} at edge t.
  - src_a/src_b and the op are latched at that edge.
  - Counter loads MULT_CYCLES or DIV_CYCLES.
  - busy=1 from cycle t+1.
- RUN:
  - Counter decrements each edge.
  - At the edge where the counter reaches its last count, hi/lo are written, busy→0 and the state returns to IDLE.
  - Net timing: busy is high for exactly N cycles (t+1 .. t+N); the new hi/lo are visible in the same cycle busy first reads 0 (t+N+1).
  - hi/lo hold their old values throughout RUN.
- mthi/mtlo (IDLE, start=1): at edge t, hi←src_a (mthi) or lo←src_a (mtlo). No busy; the other register is unchanged.
- start=1 while busy=1: ignored (hazard unit prevents it); the in-flight op completes unaffected.
- start=0, or md_op ∈ {000, 111}: no state change.
- Arithmetic:
  - mult: {hi,lo} = signed(a)×signed(b), 64-bit.
  - multu: unsigned 64-bit product.
  - div: lo = quotient truncated toward zero; hi = remainder carrying the sign of the dividend.
  - 0x80000000 div 0xFFFFFFFF → lo=0x80000000, hi=0.
  - divu: unsigned quotient in lo, remainder in hi.
  - Divisor 0 (div or divu): full latency elapses and busy behaves normally; hi and lo are left unchanged.
- Operand isolation: latched operands are used for the result, so src_a/src_b may change during RUN without effect.
- Reset mid-RUN: the operation is aborted, busy=0 and hi=lo=0 on the next cycle.
- Implementation: the result may be computed combinationally from the latched operands and committed at the final count. Only the latency and visible timing above are normative.

Test Plan:
- Reset, then multu a=0xFFFFFFFF, b=2 → busy high exactly 5 cycles; then hi=0x00000001, lo=0xFFFFFFFE; hi/lo equal 0 during busy.
- mult a=0xFFFFFFFD (−3), b=7 → after 5 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB; src_a toggled during busy has no effect.
- div a=0xFFFFFFF9 (−7), b=2 → busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also:
  - divu a=7, b=2 → lo=3, hi=1.
  - div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- mthi 0x12345678 then mtlo 0x9ABCDEF0 on consecutive cycles → hi/lo update one edge after each, busy never asserts; then divu by b=0 → busy 10 cycles, hi/lo unchanged.
- divu in flight, start=1 with mthi at busy cycle 3 → ignored; the divu result lands at cycle 10 and hi is not overwritten by the mthi value.
- mult started, reset asserted at busy cycle 2 → next cycle busy=0, hi=lo=0; no result is written afterwards.
